// File: rtl/wide_add_seq_if.sv
// Request/result bundle for wide_add_seq: operand handshake in, result handshake out.
// master = requester/consumer side, slave = the adder controller.
interface wide_add_seq_if #(
   parameter int WORDS = 4
);
   localparam int W = 64 * WORDS;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/wide_add_seq.sv
// Wide add/subtract built by stepping one shared 64-bit carry-select adder
// over the operand words, LSW first, with a registered inter-word carry.

module Con_sa_8_bit_block_64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cin,
   output logic [63:0] sum,
   output logic        cout
);
   for (genvar g = 0; g < 8; g++) begin : g_blk
      logic [8:0] s0;
      logic [8:0] s1;
      logic       ci;
      logic       co;

      if (g == 0) begin : g_first
         assign ci = cin;
      end else begin : g_rest
         assign ci = g_blk[g-1].co;
      end

      // both carry-in cases precomputed; the incoming carry only selects
      assign s0 = {1'b0, a[8*g +: 8]} + {1'b0, b[8*g +: 8]};
      assign s1 = {1'b0, a[8*g +: 8]} + {1'b0, b[8*g +: 8]} + 9'd1;
      assign sum[8*g +: 8] = ci ? s1[7:0] : s0[7:0];
      assign co = ci ? s1[8] : s0[8];
   end

   assign cout = g_blk[7].co;
endmodule

// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | one operand word per cycle through the shared adder
// DONE  | result held, out_valid high until consumed
module wide_add_seq #(
   parameter int WORDS = 4
) (
   input  logic          clk,
   input  logic          rst,
   wide_add_seq_if.slave bus
);
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [WORDS-1:0][63:0]  a_q, a_d;
   logic [WORDS-1:0][63:0]  b_q, b_d;
   logic [WORDS-1:0][63:0]  sum_q, sum_d;
   logic                    carry_q, carry_d;
   logic                    cout_q, cout_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [63:0]             add_sum;
   logic                    add_cout;

   Con_sa_8_bit_block_64 u_add (
      .a    (a_q[idx_q]),
      .b    (b_q[idx_q]),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               // subtract as a + ~b + 1
               a_d     = bus.a;
               b_d     = bus.b ^ {(64*WORDS){bus.sub}};
               carry_d = bus.sub ? 1'b1 : bus.cin;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[idx_q] = add_sum;
            carry_d      = add_cout;
            if (idx_q == LAST) begin
               cout_d  = add_cout;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-cycle wide-operand adder/subtractor controller. Accepts WORDS×64-bit operands through a valid/ready handshake. It sequences a single shared `Con_sa_8_bit_block_64` carry-select adder over the operand words, least-significant word first, with a registered inter-word carry. It returns the full-width result through a second valid/ready handshake. This lets datapaths wider than 64 bits reuse the existing 64-bit adder instead of instantiating WORDS copies of it.

## Interface
- `WORDS`, default 4: number of 64-bit words per operand; legal range ≥1. Operand width is W = 64×WORDS.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_valid` input, 1 bit: request holds valid operands.
- `in_ready` output, 1 bit: block can accept a request; high only in IDLE.
- `a` input, W bits: operand A.
- `b` input, W bits: operand B.
- `cin` input, 1 bit: carry-in for add; ignored when `sub`=1.
- `sub` input, 1 bit: 1 computes a − b, 0 computes a + b + cin.
- `out_valid` output, 1 bit: result valid; high only in DONE.
- `out_ready` input, 1 bit: consumer accepts the result.
- `sum` output, W bits: result.
- `cout` output, 1 bit: final carry. For subtract, 1 means no borrow (a ≥ b, unsigned).

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - On `in_valid`&`in_ready`, register `a`, plus `b` XOR {W{sub}}.
  - Initialise the carry register to `sub` ? 1 : `cin`.
  - Set word index to 0 and go to RUN.
  - Operand ports may change freely after the accept edge.
- **RUN**
  - Each cycle, feed the registered word idx of A and B, plus the carry register, to the adder.
  - At the edge, write the adder sum into `sum` word idx, load the adder carry-out into the carry register, and increment idx.
  - When idx = WORDS−1 at the edge, load `cout` with the adder carry-out and go to DONE.
- **DONE**
  - `out_valid`=1; `sum` and `cout` are held stable.
  - On `out_valid`&`out_ready`, go to IDLE.
  - `sum` and `cout` keep their values until overwritten by the next operation.
- Only one operation is in flight; `in_ready`=0 in RUN and DONE. A request that arrives while busy waits; the block never drops or queues it.
- Arithmetic is unsigned modulo 2^W; `cout` is bit W of the full result.
- The word index counter is max($clog2(WORDS),1) bits and never wraps past WORDS−1.
- **Reset values:** state IDLE, `in_ready`=1 (combinational from state), `out_valid`=0, `sum`=0, `cout`=0, carry register 0, idx 0.
- **Reset mid-operation** (RUN or DONE) aborts the operation. No `out_valid` is produced for the aborted request.
- **Simultaneous events:**
  - `rst` overrides any handshake in the same cycle.
  - In DONE, `out_ready` and a pending `in_valid` in the same cycle: the result handshake completes, and the new request is accepted in IDLE on a later cycle.

## Timing
- Accept at edge T.
- RUN occupies edges T+1 … T+WORDS; word k is written at edge T+1+k.
- `out_valid` rises in the cycle after edge T+WORDS, so latency is WORDS+1 cycles from accept to `out_valid`.
- With `out_ready` held high, the result handshake is at edge T+WORDS+1 and `in_ready` returns the following cycle. Minimum initiation interval is WORDS+2 cycles.
- `out_valid` is held indefinitely under back-pressure.
- Combinational path per cycle: one 64-bit adder plus operand word mux; no combinational path from inputs to outputs except state→`in_ready`/`out_valid`.
- WORDS=1 degenerates to RUN for a single cycle; latency is 2.

## Test plan
- **Full carry ripple.** WORDS=4, a=2^256−1, b=1, cin=0, sub=0, out_ready=1 → sum=0, cout=1. `out_valid` appears exactly 5 cycles after accept and lasts 1 cycle.
- **Subtract with borrow.** a=0, b=1, sub=1, cin=1 (ignored) → sum=2^256−1, cout=0. Then a=5, b=5, sub=1 → sum=0, cout=1.
- **Output back-pressure.** a=0x1_0000000000000000 (bit 64 set), b=0xFFFFFFFFFFFFFFFF, cin=1; hold out_ready=0 for 3 cycles → sum=0x2_0000000000000000 with cout=0. `out_valid`, `sum` and `cout` stay stable and `in_ready`=0 throughout; handshake on the first cycle out_ready=1.
- **Reset mid-RUN.** Assert `rst` for one cycle on the 2nd RUN cycle → next cycle `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, with no result for the aborted op. A following op a=3, b=4 gives sum=7.
- **Back-to-back requests.** `in_valid` held high with two operations queued by the bench, out_ready=1 → second accept exactly WORDS+2=6 cycles after the first, and both results are correct. Changing `a`/`b` right after accept does not corrupt the in-flight result.
- **WORDS=1 build.** a=0xFFFFFFFFFFFFFFFF, b=0, cin=1 → sum=0, cout=1, latency 2 cycles.
